// File: rtl/aggregator_pkg.sv
// Shared widths, constants and the Q1.15 saturation helper for the rule-grid aggregator.
package aggregator_pkg;

  localparam int WW        = 16;
  localparam int GW        = 8;
  localparam int GMAX      = 100;
  localparam int NUM_LANES = 9;
  localparam int SW_W      = 20;
  localparam int P_W       = 26;
  localparam int PROD_W    = WW + GW;

  localparam logic [WW-1:0] Q15_ONE = 16'h7FFF;

  typedef struct packed {
    logic [WW-1:0] s_w;
    logic [WW-1:0] s_wg;
  } agg_res_t;

  function automatic logic [WW-1:0] sat16(input logic [31:0] x);
    return (x > 32'(Q15_ONE)) ? Q15_ONE : x[WW-1:0];
  endfunction

endpackage

// File: rtl/aggregator_unit_div100_round.sv
// Exact round-half-up division by GMAX with Q1.15 saturation; purely combinational.
module div100_round
  import aggregator_pkg::*;
(
  input  logic [P_W-1:0] x,
  output logic [WW-1:0]  q,
  output logic           ovf
);

  logic [P_W:0] xr;
  logic [P_W:0] quo;

  // Constant divide is exact; the synthesiser folds it into a fixed network.
  assign xr  = {1'b0, x} + (P_W+1)'(GMAX / 2);
  assign quo = xr / (P_W+1)'(GMAX);
  assign q   = sat16(32'(quo));
  assign ovf = quo > (P_W+1)'(Q15_ONE);

endmodule

// File: rtl/aggregator_unit.sv
// 3x3 rule-grid weighted-sum aggregator: S_w = sum(w), S_wg = round(sum(w*g)/100), Q1.15.
// Optional sat output is enabled by defining AGGREGATOR_SAT_FLAG_EN.
module aggregator_unit
  import aggregator_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reg_mode,
  input  logic [WW-1:0] w00, w01, w02,
  input  logic [WW-1:0] w10, w11, w12,
  input  logic [WW-1:0] w20, w21, w22,
  input  logic [GW-1:0] g00, g01, g02,
  input  logic [GW-1:0] g10, g11, g12,
  input  logic [GW-1:0] g20, g21, g22,
  output logic [WW-1:0] S_w,
`ifdef AGGREGATOR_SAT_FLAG_EN
  output logic          sat,
`endif
  output logic [WW-1:0] S_wg
);

  logic [NUM_LANES-1:0][WW-1:0]     w_in, w_c;
  logic [NUM_LANES-1:0][GW-1:0]     g_in, g_c;
  logic [NUM_LANES-1:0][PROD_W-1:0] prod;

  logic [SW_W-1:0] sw_sum;
  logic [P_W-1:0]  p_sum;
  logic            sw_ovf, wg_ovf;
  agg_res_t        live, res_q;

  assign w_in = {w22, w21, w20, w12, w11, w10, w02, w01, w00};
  assign g_in = {g22, g21, g20, g12, g11, g10, g02, g01, g00};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign w_c[i]  = (w_in[i] > Q15_ONE) ? Q15_ONE : w_in[i];
    assign g_c[i]  = (g_in[i] > GW'(GMAX)) ? GW'(GMAX) : g_in[i];
    assign prod[i] = PROD_W'(w_c[i]) * PROD_W'(g_c[i]);
  end

  // Clamped operands bound both sums, so neither accumulator can wrap.
  always_comb begin
    sw_sum = '0;
    p_sum  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sw_sum = sw_sum + SW_W'(w_c[i]);
      p_sum  = p_sum + P_W'(prod[i]);
    end
  end

  assign sw_ovf   = sw_sum > SW_W'(Q15_ONE);
  assign live.s_w = sat16(32'(sw_sum));

  div100_round u_div (
    .x   (p_sum),
    .q   (live.s_wg),
    .ovf (wg_ovf)
  );

  // Registered copy runs continuously so a reg_mode flip selects without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= live;
  end

  assign S_w  = reg_mode ? live.s_w  : res_q.s_w;
  assign S_wg = reg_mode ? live.s_wg : res_q.s_wg;

`ifdef AGGREGATOR_SAT_FLAG_EN
  logic sat_live, sat_q;

  assign sat_live = sw_ovf | wg_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_live;
  end

  assign sat = reg_mode ? sat_live : sat_q;
`else
  logic unused_ovf;
  assign unused_ovf = sw_ovf ^ wg_ovf;
`endif

endmodule

// File: tb/tb_aggregator_unit.sv
// Scoreboard bench for aggregator_unit: combinational, registered, reset and mode-switch paths.
module tb_aggregator_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_mode;
  logic [15:0] w [9];
  logic [7:0]  g [9];
  logic [15:0] S_w, S_wg;
`ifdef AGGREGATOR_SAT_FLAG_EN
  logic        sat;
`endif

  typedef struct {
    logic [15:0] sw;
    logic [15:0] swg;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  exp_t e_y;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  aggregator_unit dut (
    .clk(clk), .rst_n(rst_n), .reg_mode(reg_mode),
    .w00(w[0]), .w01(w[1]), .w02(w[2]),
    .w10(w[3]), .w11(w[4]), .w12(w[5]),
    .w20(w[6]), .w21(w[7]), .w22(w[8]),
    .g00(g[0]), .g01(g[1]), .g02(g[2]),
    .g10(g[3]), .g11(g[4]), .g12(g[5]),
    .g20(g[6]), .g21(g[7]), .g22(g[8]),
    .S_w(S_w),
`ifdef AGGREGATOR_SAT_FLAG_EN
    .sat(sat),
`endif
    .S_wg(S_wg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    int   sw = 0;
    int   p  = 0;
    int   q;
    for (int i = 0; i < 9; i++) begin
      int wc = (w[i] > 16'h7FFF) ? 32'h7FFF : int'(w[i]);
      int gc = (g[i] > 8'd100) ? 100 : int'(g[i]);
      sw += wc;
      p  += wc * gc;
    end
    q     = (p + 50) / 100;
    e.sw  = (sw > 32'h7FFF) ? 16'h7FFF : 16'(sw);
    e.swg = (q > 32'h7FFF) ? 16'h7FFF : 16'(q);
    e.sat = (sw > 32'h7FFF) || (q > 32'h7FFF);
    return e;
  endfunction

  task automatic push_const(input logic [15:0] sw, input logic [15:0] swg, input logic s);
    exp_t e;
    e.sw = sw; e.swg = swg; e.sat = s;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %0h/%0h", tag, S_w, S_wg);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sw"}, 32'(S_w), 32'(e.sw));
      chk({tag, "_swg"}, 32'(S_wg), 32'(e.swg));
`ifdef AGGREGATOR_SAT_FLAG_EN
      chk({tag, "_sat"}, 32'(sat), 32'(e.sat));
`endif
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sw"}, 32'(S_w), 32'h0);
    chk({tag, "_swg"}, 32'(S_wg), 32'h0);
`ifdef AGGREGATOR_SAT_FLAG_EN
    chk({tag, "_sat"}, 32'(sat), 32'h0);
`endif
  endtask

  task automatic set_all(input logic [15:0] wv, input logic [7:0] gv);
    for (int i = 0; i < 9; i++) begin
      w[i] = wv;
      g[i] = gv;
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 3))
        0: w[i] = 16'h7FFF;
        1: w[i] = 16'($urandom_range(0, 16'h1FFF));
        2: w[i] = 16'($urandom);
        default: w[i] = 16'h0;
      endcase
      g[i] = ($urandom_range(0, 3) == 0) ? 8'd100 : 8'($urandom);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    reg_mode = 1'b0;
    rand_inputs();
    #1 chk_zero("reset");

    // Combinational path, with reset still held to show it is ignored there.
    reg_mode = 1'b1;
    set_all(16'h0, 8'd50); w[4] = 16'h7FFF;
    #1 push_const(16'h7FFF, 16'd16384, 1'b0); pop_cmp("center_half");

    set_all(16'h7FFF, 8'd100);
    #1 push_const(16'h7FFF, 16'h7FFF, 1'b1); pop_cmp("all_max");

    set_all(16'hFFFF, 8'd255);
    #1 push_const(16'h7FFF, 16'h7FFF, 1'b1); pop_cmp("in_clamp");

    set_all(16'h0, 8'd0); w[0] = 16'h4000; w[8] = 16'h2000; g[0] = 8'd100;
    #1 push_const(16'h6000, 16'h4000, 1'b0); pop_cmp("corners");

    set_all(16'h0, 8'd0); w[4] = 16'h7FFF; g[4] = 8'd200;
    #1 push_const(16'h7FFF, 16'h7FFF, 1'b0); pop_cmp("g_clamp");

    set_all(16'h0, 8'd100);
    #1 push_const(16'h0, 16'h0, 1'b0); pop_cmp("zero_w");

    for (int k = 0; k < 20; k++) begin
      rand_inputs();
      #1 sb.push_back(model()); pop_cmp("comb_rand");
    end

    // Registered path: zero until the first edge after reset release.
    @(negedge clk); reg_mode = 1'b0;
    #1 chk_zero("reg_in_reset");
    @(negedge clk); rst_n = 1'b1;
    set_all(16'h0, 8'd0); w[0] = 16'h4000; w[8] = 16'h2000; g[0] = 8'd100;
    push_const(16'h6000, 16'h4000, 1'b0);
    #1 chk_zero("reg_pre_edge");
    @(posedge clk); #1 pop_cmp("reg_first");

    for (int k = 0; k < 20; k++) begin
      @(negedge clk); rand_inputs(); sb.push_back(model());
      @(posedge clk); #1 pop_cmp("reg_stream");
    end

    // Mid-stream reset drops whatever was in flight.
    @(negedge clk); rand_inputs(); sb.push_back(model());
    @(posedge clk); #1 pop_cmp("pre_rst");
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk); rand_inputs();
    @(posedge clk); #1 chk_zero("rst_held");
    @(negedge clk); rst_n = 1'b1; rand_inputs(); e_y = model(); sb.push_back(e_y);
    #1 chk_zero("rst_release_pre_edge");
    @(posedge clk); #1 pop_cmp("rst_reload");

    // Mode switch picks live vs held value with no clock in between.
    @(negedge clk); rand_inputs(); reg_mode = 1'b1;
    #1 sb.push_back(model()); pop_cmp("switch_live");
    reg_mode = 1'b0;
    #1 sb.push_back(e_y); pop_cmp("switch_held");
    @(posedge clk); #1 sb.push_back(model()); pop_cmp("switch_reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
